// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences one single-cycle access at a time
// onto the single-port MEM block and returns read data or a write acknowledge.
module mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_enable,
    output logic                  mem_mode,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);
    localparam logic IDLE   = 1'b0;
    localparam logic ACCESS = 1'b1;

    logic                  state;
    logic                  last_grant;
    logic                  write_r;
    logic                  port_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  grant0;
    logic                  grant1;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (req0_valid && (!req1_valid || last_grant))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign mem_enable  = (state == ACCESS);
    assign mem_mode    = !(mem_enable && write_r);
    assign mem_address = addr_r;
    assign mem_data_in = wdata_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            write_r    <= 1'b0;
            port_r     <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        port_r     <= grant1;
                        last_grant <= grant1;
                        write_r    <= grant1 ? req1_write : req0_write;
                        addr_r     <= grant1 ? req1_addr  : req0_addr;
                        wdata_r    <= grant1 ? req1_wdata : req0_wdata;
                        state      <= ACCESS;
                    end
                end
                default: begin
                    // MEM finished the access on the falling edge of this cycle.
                    rsp0_valid <= !port_r;
                    rsp1_valid <= port_r;
                    if (!write_r)
                        rsp_rdata <= mem_data_out;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port MEM model
// that acts on the falling clock edge.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [15:0] req0_addr = '0;
    logic [7:0]  req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [15:0] req1_addr = '0;
    logic [7:0]  req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0]  rsp_rdata, mem_data_in;
    logic [7:0]  mem_data_out = '0;
    logic [15:0] mem_address;
    logic        mem_enable, mem_mode;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid),
        .rsp_rdata(rsp_rdata), .mem_address(mem_address), .mem_enable(mem_enable),
        .mem_mode(mem_mode), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(negedge clk) begin
        if (mem_enable) begin
            if (!mem_mode) mem[mem_address] <= mem_data_in;
            else           mem_data_out <= mem[mem_address];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full transaction on one port, checking access and response cycles.
    task automatic do_txn(input logic p, input logic w, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] exp_r);
        int n;
        logic rdy;
        @(posedge clk); #1;
        if (!p) begin req0_valid = 1; req0_write = w; req0_addr = a; req0_wdata = d; end
        else    begin req1_valid = 1; req1_write = w; req1_addr = a; req1_wdata = d; end
        n = 0;
        do begin
            @(negedge clk);
            rdy = p ? req1_ready : req0_ready;
            n++;
        end while (!rdy && n < 20);
        chk("grant_seen", {31'd0, rdy}, 32'd1);
        chk("other_ready", {31'd0, p ? req0_ready : req1_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        chk("acc_enable", {31'd0, mem_enable}, 32'd1);
        chk("acc_mode", {31'd0, mem_mode}, {31'd0, !w});
        chk("acc_addr", {16'd0, mem_address}, {16'd0, a});
        if (w) chk("acc_wdata", {24'd0, mem_data_in}, {24'd0, d});
        chk("acc_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, p ? 32'd2 : 32'd1);
        chk("rsp_enable", {31'd0, mem_enable}, 32'd0);
        chk("rsp_mode", {31'd0, mem_mode}, 32'd1);
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_r});
        @(posedge clk); #1;
        chk("rsp_pulse_end", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    typedef struct {
        logic       port;
        logic       write;
        logic [15:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } vec_t;
    vec_t tbl [11];
    logic [7:0] bb [4];
    logic [7:0] hold;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5};
        tbl[2]  = '{1'b1, 1'b1, 16'hFFFF, 8'h3C, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h3C};
        tbl[4]  = '{1'b1, 1'b1, 16'h0100, 8'h5A, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 16'h0200, 8'hC3, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 16'h0000, 8'h10, 8'h00};
        tbl[7]  = '{1'b1, 1'b1, 16'h0001, 8'h21, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 16'h0002, 8'h32, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 16'h0003, 8'h43, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5};
        bb[0] = 8'h10; bb[1] = 8'h21; bb[2] = 8'h32; bb[3] = 8'h43;

        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("reset_addr", {16'd0, mem_address}, 32'd0);

        // Table: writes return the held read data, reads the stored value.
        hold = 8'h00;
        for (int i = 0; i < 11; i++) begin
            if (!tbl[i].write) hold = tbl[i].rdata;
            do_txn(tbl[i].port, tbl[i].write, tbl[i].addr, tbl[i].wdata, hold);
        end

        // Reset with both ports valid, then contention straight out of reset.
        @(posedge clk); #1;
        rst = 1;
        req0_valid = 1; req0_write = 0; req0_addr = 16'h0100;
        req1_valid = 1; req1_write = 0; req1_addr = 16'h0200;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            if (r == 1) begin
                chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
                chk("rst_enable", {31'd0, mem_enable}, 32'd0);
                chk("rst_mode", {31'd0, mem_mode}, 32'd1);
                chk("rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
                chk("rst_addr", {16'd0, mem_address}, 32'd0);
                chk("rst_wdata", {24'd0, mem_data_in}, 32'd0);
                chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
            end else begin
                chk("rst_ready0", {30'd0, req0_ready, req1_ready}, 32'd0);
            end
            @(posedge clk); #1;
        end
        rst = 0;
        for (int k = 0; k <= 16; k++) begin
            if (k == 16) begin req0_valid = 0; req1_valid = 0; end
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("cont_ready0", {31'd0, req0_ready}, {31'd0, k % 4 == 0 && k < 16});
                chk("cont_ready1", {31'd0, req1_ready}, {31'd0, k % 4 == 2});
                chk("cont_rsp0", {31'd0, rsp0_valid}, {31'd0, k % 4 == 2});
                chk("cont_rsp1", {31'd0, rsp1_valid}, {31'd0, k % 4 == 0 && k > 0});
                if (k % 4 == 2)           chk("cont_rdata0", {24'd0, rsp_rdata}, 32'h5A);
                if (k % 4 == 0 && k > 0)  chk("cont_rdata1", {24'd0, rsp_rdata}, 32'hC3);
            end else begin
                chk("cont_enable", {31'd0, mem_enable}, 32'd1);
                chk("cont_addr", {16'd0, mem_address}, (k % 4 == 1) ? 32'h0100 : 32'h0200);
                chk("cont_acc_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            end
            @(posedge clk); #1;
        end

        // Back-to-back reads from port 0 alone.
        req0_valid = 1; req0_write = 0; req0_addr = 16'h0000;
        for (int k = 0; k <= 8; k++) begin
            if (k % 2 == 1 && k < 7) req0_addr = 16'((k + 1) / 2);
            if (k == 7) req0_valid = 0;
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("b2b_ready", {31'd0, req0_ready}, {31'd0, k < 8});
                chk("b2b_rsp", {31'd0, rsp0_valid}, {31'd0, k > 0});
                if (k > 0) chk("b2b_rdata", {24'd0, rsp_rdata}, {24'd0, bb[k/2-1]});
            end else begin
                chk("b2b_enable", {31'd0, mem_enable}, 32'd1);
                chk("b2b_addr", {16'd0, mem_address}, (k - 1) / 2);
                chk("b2b_mode", {31'd0, mem_mode}, 32'd1);
            end
            @(posedge clk); #1;
        end

        // Reset arriving during a write access.
        req0_valid = 1; req0_write = 1; req0_addr = 16'h0010; req0_wdata = 8'h77;
        @(negedge clk);
        chk("mid_ready", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 0;
        chk("mid_enable", {31'd0, mem_enable}, 32'd1);
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("mid_enable_rst", {31'd0, mem_enable}, 32'd0);
        chk("mid_addr_rst", {16'd0, mem_address}, 32'd0);
        chk("mid_rdata_rst", {24'd0, rsp_rdata}, 32'd0);
        rst = 0;
        @(posedge clk); #1;
        chk("mid_rsp_after", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        do_txn(1'b0, 1'b0, 16'h0010, 8'h00, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port `MEM` block. It accepts read and write requests from two clients with valid/ready handshakes and grants them round-robin. It drives `MEM`'s `address`/`enable`/`mode`/`data_in` for exactly one cycle per transaction, then returns read data or a write acknowledge. It sits between the CPU core (port 0) and a secondary master such as a loader or DMA (port 1), and the memory.

## Interface
- `DATA_WIDTH`, 8, data bus width; must match `MEM`.
- `ADDR_WIDTH`, 16, address width; must match `MEM`.

Clocking: one clock `clk`. Reset `rst` is synchronous, active-high, sampled on rising `clk`.

- `clk` in 1 — system clock; all arbiter state updates on rising edge.
- `rst` in 1 — synchronous active-high reset.
- `req0_valid` in 1 — port 0 request present.
- `req0_ready` out 1 — port 0 request accepted this cycle.
- `req0_write` in 1 — 1 = write, 0 = read.
- `req0_addr` in ADDR_WIDTH — port 0 address.
- `req0_wdata` in DATA_WIDTH — port 0 write data.
- `rsp0_valid` out 1 — one-cycle pulse: port 0 transaction complete.
- `req1_*` / `rsp1_valid` — identical set for port 1.
- `rsp_rdata` out DATA_WIDTH — read data, valid while `rsp0_valid` or `rsp1_valid` is high for a read.
- `mem_address` out ADDR_WIDTH — to `MEM.address`.
- `mem_enable` out 1 — to `MEM.enable`.
- `mem_mode` out 1 — to `MEM.mode`; 1 = read, 0 = write.
- `mem_data_in` out DATA_WIDTH — to `MEM.data_in`.
- `mem_data_out` in DATA_WIDTH — from `MEM.data_out`; high-Z unless reading.

## Operation
- States: `IDLE` and `ACCESS`.
- **IDLE**
  - `req0_ready`/`req1_ready` are combinational.
  - If only one `reqN_valid` is high, that port gets `ready`.
  - If both are high, the port other than `last_grant` gets `ready`.
  - At most one `ready` is high per cycle.
  - On handshake (`valid && ready` at the rising edge):
    - register addr, write flag, wdata and the granted port;
    - set `last_grant` to the granted port;
    - go to `ACCESS`.
- **ACCESS**
  - `mem_enable`=1, `mem_address`/`mem_data_in` come from registers, `mem_mode` = !write.
  - Both `ready` outputs are 0.
  - `MEM` performs the access on the falling edge inside this cycle.
  - At the next rising edge:
    - pulse `rspN_valid` for the granted port for one cycle;
    - on a read, load `rsp_rdata` from `mem_data_out`;
    - on a write, hold `rsp_rdata`;
    - go to `IDLE`.
- **Response cycle and backpressure**
  - The response cycle is an `IDLE` cycle, so a new request may be accepted in the same cycle that `rspN_valid` is high.
  - Responses have no backpressure; clients must sample `rspN_valid` when it is high.
- **Bus ownership**
  - Outside `ACCESS`: `mem_enable`=0, `mem_mode`=1, and `mem_address`/`mem_data_in` hold their last values.
  - `mem_data_out` is sampled only at the end of a read `ACCESS` cycle, never when it is high-Z.
- **Fairness**
  - With both ports continuously valid, grants strictly alternate.
  - A single active port is granted every 2 cycles with no extra bubble.
- Request fields must be held stable by the requester only while `valid && !ready`. After the handshake the arbiter works from its registered copy.

## Timing
- **Reset values**
  - state = `IDLE`, `last_grant` = 1 (port 0 wins the first tie).
  - `mem_enable`=0, `mem_mode`=1, `mem_address`=0, `mem_data_in`=0.
  - `rspN_valid`=0, `rsp_rdata`=0.
  - `reqN_ready`=0 while `rst` is high.
- **Latency**
  - Handshake at edge E0; `mem_enable` high E0→E1; `rspN_valid` high E1→E2, with `rsp_rdata` valid in that window.
- **Throughput:** 1 transaction per 2 cycles.
- **Reset during ACCESS**
  - A write is already committed at that cycle's falling edge.
  - At the reset edge: no `rspN_valid` is issued, state → `IDLE`, and all outputs take their reset values.
- **Reset in the response cycle:** the `rspN_valid` pulse already raised stays high for that cycle; all outputs clear at the next edge.
- **Simultaneous valid with `last_grant`=0:** port 1 is granted, and `req0_ready` stays 0 that cycle.
- **Port dropping valid:** a requester deasserting valid before ready cancels its request; no memory access occurs.
- **Address wrap:** none. Addresses pass through unmodified and the full `ADDR_WIDTH` range is legal.

## Test plan
- **Reset:** assert `rst` 2 cycles with both ports valid → `ready`=0, `mem_enable`=0, `mem_mode`=1, `rsp*`=0 throughout.
- **Single read:** memory preloaded with `mem[0x1234]`=0xA5; port 0 read 0x1234 → `mem_enable` for exactly 1 cycle with `mem_mode`=1; `rsp0_valid` pulse next cycle with `rsp_rdata`=0xA5.
- **Write then read:** port 1 writes 0x3C to 0xFFFF, then reads 0xFFFF → write cycle has `mem_mode`=0 and `mem_data_in`=0x3C; `rsp1_valid` pulses twice; read returns 0x3C.
- **Contention:** both ports hold valid for 8 grants after reset → grant order 0,1,0,1,…; a new handshake every 2 cycles; each `rspN_valid` goes only to its own port.
- **Back-to-back:** port 0 alone issues reads to 0x0000–0x0003 continuously → a handshake in every response cycle; 4 transactions complete in 8 cycles; data in order.
- **Reset mid-access:** write 0x77 to 0x0010, assert `rst` during `ACCESS` → no `rsp0_valid`; a read of 0x0010 after reset returns 0x77.
